// File: rtl/rom_hdr_pkg.sv
// rtl/rom_hdr_pkg.sv - shared types, field offsets and scoring helpers for the ROM header scanner
package rom_hdr_pkg;

    typedef enum logic [7:0] {
        MAP_LO   = 8'd0,
        MAP_HI   = 8'd1,
        MAP_EXHI = 8'd5
    } map_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_SCORE0,
        S_SCORE1,
        S_SCORE2,
        S_DECIDE
    } state_e;

    localparam logic [23:0] OFS_MAP  = 24'h000014;
    localparam logic [23:0] OFS_TYPE = 24'h000016;
    localparam logic [23:0] OFS_RAM  = 24'h000018;
    localparam logic [23:0] OFS_CHKC = 24'h00001C;
    localparam logic [23:0] OFS_CHK  = 24'h00001E;
    localparam logic [23:0] OFS_VEC  = 24'h00003C;

    localparam logic [3:0] W_CHK  = 4'd4;
    localparam logic [3:0] W_MAP  = 4'd2;
    localparam logic [3:0] W_SIZE = 4'd1;
    localparam logic [3:0] W_VEC  = 4'd1;

    typedef struct packed {
        logic [7:0]  map_mode;
        logic [7:0]  cart_type;
        logic [3:0]  rom_size;
        logic [3:0]  ram_size;
        logic [7:0]  region;
        logic [15:0] chk_comp;
        logic [15:0] chk;
        logic [15:0] vector;
    } hdr_fields_t;

    function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[4] ? 4'hF : s[3:0];
    endfunction

    // map_idx: 0 LoROM, 1 HiROM, 2 ExHiROM
    function automatic logic [3:0] score_hdr(input hdr_fields_t h, input logic [1:0] map_idx);
        logic [3:0] s;
        logic       map_ok;
        s = 4'd0;
        case (map_idx)
            2'd0:    map_ok = ~h.map_mode[0];
            2'd1:    map_ok = h.map_mode[0];
            default: map_ok = (h.map_mode[3:0] == 4'h5);
        endcase
        if ((h.chk ^ h.chk_comp) == 16'hFFFF) s = sat_add(s, W_CHK);
        if (map_ok) s = sat_add(s, W_MAP);
        if (h.rom_size >= 4'd8 && h.rom_size <= 4'd13) s = sat_add(s, W_SIZE);
        if (h.vector >= 16'h8000) s = sat_add(s, W_VEC);
        return s;
    endfunction

endpackage

// File: rtl/rom_header_scan_if.sv
// rtl/rom_header_scan_if.sv - HPS ioctl download word-write bus
interface rom_header_scan_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [15:0] ioctl_dout;

    modport master (output ioctl_download, output ioctl_wr, output ioctl_addr, output ioctl_dout);
    modport slave  (input  ioctl_download, input  ioctl_wr, input  ioctl_addr, input  ioctl_dout);
endinterface

// File: rtl/rom_hdr_capture.sv
// rtl/rom_hdr_capture.sv - latches the header fields of one candidate base from the download stream
module rom_hdr_capture
    import rom_hdr_pkg::*;
#(
    parameter logic [23:0] BASE = 24'h007FC0
) (
    input  logic        clk_i,
    input  logic        clear_i,
    input  logic        wr_i,
    input  logic [24:0] addr_i,
    input  logic [15:0] dout_i,
    output hdr_fields_t fields_o
);

    hdr_fields_t f_q;
    logic [23:0] ofs;

    // Addresses below BASE wrap to large values and never hit a field offset.
    assign ofs = addr_i[23:0] - BASE;

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            f_q <= '0;
        end else if (wr_i && !addr_i[24]) begin
            case (ofs)
                OFS_MAP:  f_q.map_mode <= dout_i[15:8];
                OFS_TYPE: begin
                    f_q.cart_type <= dout_i[7:0];
                    f_q.rom_size  <= dout_i[11:8];
                end
                OFS_RAM:  begin
                    f_q.ram_size <= dout_i[3:0];
                    f_q.region   <= dout_i[15:8];
                end
                OFS_CHKC: f_q.chk_comp <= dout_i;
                OFS_CHK:  f_q.chk      <= dout_i;
                OFS_VEC:  f_q.vector   <= dout_i;
                default:  ;
            endcase
        end
    end

    assign fields_o = f_q;

endmodule

// File: rtl/rom_header_scan.sv
// rtl/rom_header_scan.sv - snoops the ROM download, scores header candidates and selects the cart mapping
module rom_header_scan
    import rom_hdr_pkg::*;
#(
    parameter logic [23:0] LOROM_OFS    = 24'h007FC0,
    parameter logic [23:0] HIROM_OFS    = 24'h00FFC0,
    parameter logic [23:0] EXHI_OFS     = 24'h40FFC0,
    parameter logic [23:0] COPIER_OFS   = 24'h000200,
    parameter logic [3:0]  RAM_SIZE_MAX = 4'h7
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    rom_header_scan_if.slave         ioctl,
    input  logic [2:0]               force_type,
    output logic [7:0]               rom_type,
    output logic [23:0]              rom_mask,
    output logic [23:0]              ram_mask,
    output logic                     rom_region,
    output logic                     busy,
    output logic                     done
);

    state_e      state_q;
    logic        dl_q;
    logic [24:0] max_addr_q;
    logic        headered_q;
    logic [3:0]  lo_score_q, hi_score_q, ex_score_q;
    map_e        rom_type_q;
    logic [23:0] rom_mask_q, ram_mask_q;
    logic        rom_region_q, busy_q, done_q;

    logic        dl_rise, wr_en, cap_clear, headered_d;
    hdr_fields_t cand [6];

    assign dl_rise   = ioctl.ioctl_download && !dl_q;
    assign wr_en     = (state_q == S_CAPTURE) && ioctl.ioctl_download && ioctl.ioctl_wr;
    assign cap_clear = reset || dl_rise;

    // Candidate index = {map, copier}: 0/1 Lo, 2/3 Hi, 4/5 ExHi.
    for (genvar g = 0; g < 6; g++) begin : g_cap
        localparam logic [23:0] MAP_BASE  = (g / 2 == 0) ? LOROM_OFS :
                                            (g / 2 == 1) ? HIROM_OFS : EXHI_OFS;
        localparam logic [23:0] CAND_BASE = MAP_BASE + ((g % 2 == 1) ? COPIER_OFS : 24'h0);
        rom_hdr_capture #(.BASE(CAND_BASE)) u_cap (
            .clk_i    (clk_sys),
            .clear_i  (cap_clear),
            .wr_i     (wr_en),
            .addr_i   (ioctl.ioctl_addr),
            .dout_i   (ioctl.ioctl_dout),
            .fields_o (cand[g])
        );
    end

    assign headered_d = (((max_addr_q + 25'd2) & 25'h0003FF) == 25'h000200) && (force_type != 3'd1);

    logic [1:0]  score_map;
    hdr_fields_t score_f;
    logic [3:0]  score_d;

    always_comb begin
        score_map = 2'd0;
        case (state_q)
            S_SCORE1: score_map = 2'd1;
            S_SCORE2: score_map = 2'd2;
            default:  score_map = 2'd0;
        endcase
        score_f = cand[{score_map, headered_q}];
        score_d = score_hdr(score_f, score_map);
        // An ExHiROM header cannot be genuine in a file smaller than 4 MB.
        if (score_map == 2'd2 && max_addr_q < 25'h0400000) score_d = 4'd0;
    end

    logic [1:0]  pick;
    hdr_fields_t pick_f;
    map_e        rom_type_d;
    logic [3:0]  rom_code, ram_code;
    logic [4:0]  rom_sh, ram_sh;
    logic [23:0] rom_mask_d, ram_mask_d;
    logic        rom_region_d;

    always_comb begin
        pick = 2'd0;
        case (force_type)
            3'd2: pick = 2'd0;
            3'd3: pick = 2'd1;
            3'd4: pick = 2'd2;
            default: begin
                if (lo_score_q >= hi_score_q && lo_score_q >= ex_score_q) pick = 2'd0;
                else if (hi_score_q >= ex_score_q)                         pick = 2'd1;
                else                                                       pick = 2'd2;
            end
        endcase
        case (pick)
            2'd0:    rom_type_d = MAP_LO;
            2'd1:    rom_type_d = MAP_HI;
            default: rom_type_d = MAP_EXHI;
        endcase
        pick_f       = cand[{pick, headered_q}];
        rom_code     = (pick_f.rom_size >= 4'd8 && pick_f.rom_size <= 4'd13) ? pick_f.rom_size : 4'd12;
        ram_code     = (pick_f.ram_size > RAM_SIZE_MAX) ? RAM_SIZE_MAX : pick_f.ram_size;
        rom_sh       = 5'd10 + {1'b0, rom_code};
        ram_sh       = 5'd10 + {1'b0, ram_code};
        rom_mask_d   = (24'd1 << rom_sh) - 24'd1;
        ram_mask_d   = (pick_f.ram_size == 4'd0) ? 24'd0 : ((24'd1 << ram_sh) - 24'd1);
        rom_region_d = (pick_f.region >= 8'd2) && (pick_f.region <= 8'd12);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= S_IDLE;
            dl_q         <= 1'b0;
            max_addr_q   <= '0;
            headered_q   <= 1'b0;
            lo_score_q   <= '0;
            hi_score_q   <= '0;
            ex_score_q   <= '0;
            rom_type_q   <= MAP_LO;
            rom_mask_q   <= 24'h3FFFFF;
            ram_mask_q   <= '0;
            rom_region_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            dl_q   <= ioctl.ioctl_download;
            done_q <= 1'b0;
            // A new download always restarts capture, abandoning any scoring in flight.
            if (dl_rise) begin
                state_q    <= S_CAPTURE;
                max_addr_q <= '0;
                busy_q     <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: ;
                    S_CAPTURE: begin
                        if (!ioctl.ioctl_download) begin
                            headered_q <= headered_d;
                            state_q    <= S_SCORE0;
                        end else if (ioctl.ioctl_wr) begin
                            max_addr_q <= ioctl.ioctl_addr;
                        end
                    end
                    S_SCORE0: begin
                        lo_score_q <= score_d;
                        state_q    <= S_SCORE1;
                    end
                    S_SCORE1: begin
                        hi_score_q <= score_d;
                        state_q    <= S_SCORE2;
                    end
                    S_SCORE2: begin
                        ex_score_q <= score_d;
                        state_q    <= S_DECIDE;
                    end
                    S_DECIDE: begin
                        rom_type_q   <= rom_type_d;
                        rom_mask_q   <= rom_mask_d;
                        ram_mask_q   <= ram_mask_d;
                        rom_region_q <= rom_region_d;
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign rom_type   = rom_type_q;
    assign rom_mask   = rom_mask_q;
    assign ram_mask   = ram_mask_q;
    assign rom_region = rom_region_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_rom_header_scan.sv
// tb/tb_rom_header_scan.sv - directed scoreboard bench for rom_header_scan
module tb_rom_header_scan;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  force_type = 3'd0;
    logic [7:0]  rom_type;
    logic [23:0] rom_mask, ram_mask;
    logic        rom_region, busy, done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  rtype;
        logic [23:0] rmask;
        logic [23:0] amask;
        logic        region;
    } exp_t;

    exp_t sb[$];

    rom_header_scan_if bus ();

    rom_header_scan dut (
        .clk_sys    (clk),
        .reset      (reset),
        .ioctl      (bus),
        .force_type (force_type),
        .rom_type   (rom_type),
        .rom_mask   (rom_mask),
        .ram_mask   (ram_mask),
        .rom_region (rom_region),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input logic [24:0] a, input logic [15:0] d);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        tick();
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic hdr(input logic [24:0] b, input logic [7:0] mm, input logic [3:0] rs,
                       input logic [3:0] ms, input logic [7:0] rg, input logic ok);
        wr_word(b + 25'h14, {mm, 8'h00});
        wr_word(b + 25'h16, {4'h0, rs, 8'h02});
        wr_word(b + 25'h18, {rg, 4'h0, ms});
        wr_word(b + 25'h1C, ok ? 16'hEDCB : 16'h0000);
        wr_word(b + 25'h1E, 16'h1234);
        wr_word(b + 25'h3C, 16'h8000);
    endtask

    task automatic start_dl(input string tag);
        bus.ioctl_download = 1'b1;
        tick();
        check({tag, "_busy_start"}, busy, 1);
    endtask

    task automatic end_dl(input string tag, input logic [7:0] t, input logic [23:0] rm,
                          input logic [23:0] am, input logic rg);
        exp_t e, got;
        int   n;
        e.rtype = t; e.rmask = rm; e.amask = am; e.region = rg;
        sb.push_back(e);
        bus.ioctl_download = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (done !== 1'b1 && n < 20);
        // Edge 1 is the first one sampling download low; done follows 4 cycles later.
        check({tag, "_latency"}, n, 5);
        got = sb.pop_front();
        check({tag, "_rom_type"}, rom_type, got.rtype);
        check({tag, "_rom_mask"}, rom_mask, got.rmask);
        check({tag, "_ram_mask"}, ram_mask, got.amask);
        check({tag, "_rom_region"}, rom_region, got.region);
        check({tag, "_busy_end"}, busy, 0);
        tick();
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_rom_type", rom_type, 8'd0);
        check("rst_rom_mask", rom_mask, 24'h3FFFFF);
        check("rst_ram_mask", ram_mask, 24'd0);
        check("rst_region", rom_region, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // Unheadered 1 MB LoROM
        start_dl("lo1m");
        hdr(25'h007FC0, 8'h20, 4'hA, 4'h3, 8'h01, 1'b1);
        wr_word(25'h0FFFFE, 16'h0000);
        end_dl("lo1m", 8'd0, 24'h0FFFFF, 24'h001FFF, 1'b0);

        // Headered 2 MB HiROM with an unheadered LoROM decoy
        start_dl("hi2m");
        hdr(25'h007FC0, 8'h20, 4'hA, 4'h3, 8'h01, 1'b1);
        hdr(25'h0101C0, 8'h21, 4'hB, 4'h0, 8'h02, 1'b1);
        wr_word(25'h2001FE, 16'h0000);
        end_dl("hi2m", 8'd1, 24'h1FFFFF, 24'h000000, 1'b1);

        // Equal Lo/Hi scores, auto then forced HiROM
        for (int f = 0; f < 2; f++) begin
            force_type = (f == 0) ? 3'd0 : 3'd3;
            start_dl(f == 0 ? "tie" : "force_hi");
            hdr(25'h007FC0, 8'h20, 4'hA, 4'h1, 8'h0C, 1'b1);
            hdr(25'h00FFC0, 8'h21, 4'hA, 4'h1, 8'h0C, 1'b1);
            wr_word(25'h0FFFFE, 16'h0000);
            end_dl(f == 0 ? "tie" : "force_hi", (f == 0) ? 8'd0 : 8'd1, 24'h0FFFFF, 24'h0007FF, 1'b1);
        end
        force_type = 3'd0;

        // 6 MB ExHiROM
        start_dl("exhi6m");
        hdr(25'h40FFC0, 8'h25, 4'hD, 4'h0, 8'h00, 1'b1);
        wr_word(25'h5FFFFE, 16'h0000);
        end_dl("exhi6m", 8'd5, 24'h7FFFFF, 24'h000000, 1'b0);

        // Reset while scoring HiROM candidate
        start_dl("rst_score");
        hdr(25'h007FC0, 8'h20, 4'hA, 4'h3, 8'h01, 1'b1);
        wr_word(25'h0FFFFE, 16'h0000);
        bus.ioctl_download = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rst_mid_rom_type", rom_type, 8'd0);
        check("rst_mid_rom_mask", rom_mask, 24'h3FFFFF);
        check("rst_mid_ram_mask", ram_mask, 24'd0);
        check("rst_mid_region", rom_region, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rst_mid_no_done", done, 0);
        end

        // ExHi header written early but file ends at 3 MB: ExHi must lose
        start_dl("exhi3m");
        hdr(25'h40FFC0, 8'h25, 4'hD, 4'h0, 8'h00, 1'b1);
        hdr(25'h00FFC0, 8'h21, 4'h9, 4'h2, 8'h00, 1'b0);
        wr_word(25'h2FFFFE, 16'h0000);
        end_dl("exhi3m", 8'd1, 24'h07FFFF, 24'h000FFF, 1'b0);

        // RAM size clamp, ROM size fallback, region just above the PAL range
        start_dl("clamp");
        hdr(25'h007FC0, 8'h20, 4'h0, 4'h9, 8'h0D, 1'b1);
        wr_word(25'h0FFFFE, 16'h0000);
        end_dl("clamp", 8'd0, 24'h3FFFFF, 24'h01FFFF, 1'b0);

        // New download rising edge during DECIDE aborts; capture restarts clean
        start_dl("abort");
        hdr(25'h007FC0, 8'h20, 4'hA, 4'h3, 8'h01, 1'b1);
        wr_word(25'h0FFFFE, 16'h0000);
        bus.ioctl_download = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_early_done", done, 0);
        end
        bus.ioctl_download = 1'b1;
        tick();
        check("abort_done", done, 0);
        check("abort_busy", busy, 1);
        check("abort_ram_mask_held", ram_mask, 24'h01FFFF);
        hdr(25'h40FFC0, 8'h25, 4'hD, 4'h0, 8'h00, 1'b1);
        wr_word(25'h5FFFFE, 16'h0000);
        end_dl("abort_restart", 8'd5, 24'h7FFFFF, 24'h000000, 1'b0);

        // Zero-length download
        start_dl("empty");
        end_dl("empty", 8'd0, 24'h3FFFFF, 24'h000000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
